// File: rtl/rf_read_scheduler.sv
// rf_read_scheduler
// Round-robin allocation of NUM_PORTS register-file read ports among NUM_REQ
// requesters. Grants, port enables and addresses are combinational from the
// current requests, port blocks and the registered rotating pointer. Read data
// is routed back one cycle later through a registered per-requester port select.
// Optional feature macro: RF_READ_SHARE_EN -- a request whose tag matches an
// address already placed on a port this cycle rides on that port.
module rf_read_scheduler #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = 3,
  parameter int TAG_W     = 7,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          IN_reqValid,
  input  logic [NUM_REQ*TAG_W-1:0]    IN_reqTag,
  output logic [NUM_REQ-1:0]          OUT_reqReady,
  input  logic [NUM_PORTS-1:0]        IN_portBlock,
  output logic [NUM_PORTS-1:0]        OUT_readEnable,
  output logic [NUM_PORTS*TAG_W-1:0]  OUT_readAddress,
  input  logic [NUM_PORTS*DATA_W-1:0] IN_readData,
  output logic [NUM_REQ-1:0]          OUT_rspValid,
  output logic [NUM_REQ*DATA_W-1:0]   OUT_rspData
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Registered state
  logic [PTR_W-1:0] r_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [SEL_W-1:0] r_sel [NUM_REQ];

  // Combinational allocation results
  logic [TAG_W-1:0] w_tag [NUM_REQ];
  logic [TAG_W-1:0] w_addr [NUM_PORTS];
  logic [SEL_W-1:0] w_sel [NUM_REQ];
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_PORTS-1:0] w_alloc;
  logic w_any_grant;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W:0] w_sum;
  logic [PTR_W-1:0] w_idx;
  logic w_done;

  // Unpack the flat tag bus into one tag per requester
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      w_tag[r] = IN_reqTag[r*TAG_W +: TAG_W];
    end
  end

  // Scan requesters from the pointer, wrapping, and hand out free ports in index order
  always_comb begin
    w_ready     = '0;
    w_alloc     = '0;
    w_any_grant = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_sum       = '0;
    w_idx       = '0;
    w_done      = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_addr[p] = '0;
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      w_sel[r] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end else begin
        w_sum = w_sum;
      end
      w_idx  = w_sum[PTR_W-1:0];
      w_done = 1'b0;
      // No grants at all while reset is held
      if (rst && IN_reqValid[w_idx]) begin
`ifdef RF_READ_SHARE_EN
        // Ride on a port already reading the same register; needs no free port
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!w_done && w_alloc[p] && (w_addr[p] == w_tag[w_idx])) begin
            w_done       = 1'b1;
            w_sel[w_idx] = SEL_W'(p);
          end else begin
            w_done = w_done;
          end
        end
`endif
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!w_done && !w_alloc[p] && !IN_portBlock[p]) begin
            w_done       = 1'b1;
            w_alloc[p]   = 1'b1;
            w_addr[p]    = w_tag[w_idx];
            w_sel[w_idx] = SEL_W'(p);
          end else begin
            w_done = w_done;
          end
        end
        if (w_done) begin
          w_ready[w_idx] = 1'b1;
          w_any_grant    = 1'b1;
          // Pointer lands just past the last requester granted in scan order
          w_ptr_nxt = (w_idx == PTR_W'(NUM_REQ-1)) ? '0 : (w_idx + PTR_W'(1));
        end else begin
          w_ready[w_idx] = 1'b0;
        end
      end else begin
        w_done = 1'b0;
      end
    end
  end

  // Pointer, response strobes and port selects; cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        r_sel[r] <= '0;
      end
    end else begin
      if (w_any_grant) begin
        r_ptr <= w_ptr_nxt;
      end
      r_rsp_valid <= w_ready;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (w_ready[r]) begin
          r_sel[r] <= w_sel[r];
        end
      end
    end
  end

  // Drive grant and port outputs from the allocation
  always_comb begin
    OUT_reqReady   = w_ready;
    OUT_readEnable = w_alloc;
    for (int p = 0; p < NUM_PORTS; p++) begin
      OUT_readAddress[p*TAG_W +: TAG_W] = w_addr[p];
    end
  end

  // Route each requester's data from the port it was granted last cycle
  always_comb begin
    OUT_rspValid = r_rsp_valid;
    for (int r = 0; r < NUM_REQ; r++) begin
      OUT_rspData[r*DATA_W +: DATA_W] = IN_readData[0 +: DATA_W];
      for (int p = 1; p < NUM_PORTS; p++) begin
        if (r_sel[r] == SEL_W'(p)) begin
          OUT_rspData[r*DATA_W +: DATA_W] = IN_readData[p*DATA_W +: DATA_W];
        end else begin
          OUT_rspData[r*DATA_W +: DATA_W] = OUT_rspData[r*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_read_scheduler.sv
// Testbench for rf_read_scheduler (NUM_REQ=6, NUM_PORTS=3, TAG_W=7, DATA_W=32).
// Table of per-cycle vectors with hand-computed grants, plus a stall-hold sequence.
module tb_rf_read_scheduler;

  logic         clk;
  logic         rst;
  logic [5:0]   IN_reqValid;
  logic [41:0]  IN_reqTag;
  logic [5:0]   OUT_reqReady;
  logic [2:0]   IN_portBlock;
  logic [2:0]   OUT_readEnable;
  logic [20:0]  OUT_readAddress;
  logic [95:0]  IN_readData;
  logic [5:0]   OUT_rspValid;
  logic [191:0] OUT_rspData;

  int n_checks;
  int n_errors;

  rf_read_scheduler #(.NUM_REQ(6), .NUM_PORTS(3), .TAG_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .IN_reqValid(IN_reqValid), .IN_reqTag(IN_reqTag), .OUT_reqReady(OUT_reqReady),
    .IN_portBlock(IN_portBlock), .OUT_readEnable(OUT_readEnable),
    .OUT_readAddress(OUT_readAddress), .IN_readData(IN_readData),
    .OUT_rspValid(OUT_rspValid), .OUT_rspData(OUT_rspData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  valid;
    logic [41:0] tags;
    logic [2:0]  blk;
    logic [5:0]  rdy;
    logic [2:0]  en;
    logic [20:0] addr;
    logic [11:0] sel;
    logic [5:0]  rspv;
  } vec_t;

  vec_t vq[$];

  function automatic logic [41:0] tg(input logic [6:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  function automatic logic [20:0] pk3(input logic [6:0] a, b, c);
    return {c, b, a};
  endfunction

  function automatic logic [11:0] sl(input logic [1:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  function automatic logic [31:0] rd(input int cyc, input int p);
    return 32'hA500_0000 | (32'(cyc) << 8) | 32'(p);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] v, input logic [41:0] t, input logic [2:0] b,
                     input logic [5:0] rdy, input logic [2:0] en, input logic [20:0] a,
                     input logic [11:0] s, input logic [5:0] rv);
    vec_t x;
    x.rst = r; x.valid = v; x.tags = t; x.blk = b; x.rdy = rdy;
    x.en = en; x.addr = a; x.sel = s; x.rspv = rv;
    vq.push_back(x);
  endtask

  task automatic drive(input int cyc, input logic r, input logic [5:0] v,
                       input logic [41:0] t, input logic [2:0] b);
    rst          = r;
    IN_reqValid  = v;
    IN_reqTag    = t;
    IN_portBlock = b;
    IN_readData  = {rd(cyc, 2), rd(cyc, 1), rd(cyc, 0)};
  endtask

  // Requester contract monitor: a pending, not-ready request must stay valid with the same tag
  logic        chk_en;
  logic        have_prev;
  logic [5:0]  pend_prev;
  logic [41:0] tag_prev;
  always @(posedge clk) begin
    if (chk_en && have_prev) begin
      for (int r = 0; r < 6; r++) begin
        if (pend_prev[r] && (!IN_reqValid[r] || (IN_reqTag[r*7 +: 7] != tag_prev[r*7 +: 7])))
          $error("FAIL contract: requester %0d dropped or changed before ready", r);
      end
    end
    pend_prev <= IN_reqValid & ~OUT_reqReady;
    tag_prev  <= IN_reqTag;
    have_prev <= chk_en;
  end

  logic [11:0] prev_sel;
  logic [31:0] exp_d;

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    prev_sel = '0;
    drive(0, 1'b0, 6'b0, 42'b0, 3'b0);

    // rst valid tags                                  blk     rdy        en      addr                     sel                       rspv
    add(1'b0, 6'b111111, tg(7'h10,7'h11,7'h12,7'h13,7'h14,7'h15), 3'b000, 6'b000000, 3'b000, pk3(7'h0,7'h0,7'h0), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b000000);
    add(1'b0, 6'b111111, tg(7'h10,7'h11,7'h12,7'h13,7'h14,7'h15), 3'b000, 6'b000000, 3'b000, pk3(7'h0,7'h0,7'h0), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b000000);
    // full load, ptr 0 -> 3, then 3 -> 0
    add(1'b1, 6'b111111, tg(7'h10,7'h11,7'h12,7'h13,7'h14,7'h15), 3'b000, 6'b000111, 3'b111, pk3(7'h10,7'h11,7'h12), sl(2'd0,2'd1,2'd2,2'd0,2'd0,2'd0), 6'b000000);
    add(1'b1, 6'b111111, tg(7'h10,7'h11,7'h12,7'h13,7'h14,7'h15), 3'b000, 6'b111000, 3'b111, pk3(7'h13,7'h14,7'h15), sl(2'd0,2'd0,2'd0,2'd0,2'd1,2'd2), 6'b000111);
    // single grant moves ptr to 4
    add(1'b1, 6'b001000, tg(7'h00,7'h00,7'h00,7'h23,7'h00,7'h00), 3'b000, 6'b001000, 3'b001, pk3(7'h23,7'h00,7'h00), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b111000);
    // wrap: 4,5,0 granted, 1 stalled, ptr -> 1
    add(1'b1, 6'b110011, tg(7'h30,7'h31,7'h00,7'h00,7'h34,7'h35), 3'b000, 6'b110001, 3'b111, pk3(7'h34,7'h35,7'h30), sl(2'd2,2'd0,2'd0,2'd0,2'd0,2'd1), 6'b001000);
    // stalled requester 1 served, then 5; ptr -> 0
    add(1'b1, 6'b100010, tg(7'h00,7'h31,7'h00,7'h00,7'h00,7'h45), 3'b000, 6'b100010, 3'b011, pk3(7'h31,7'h45,7'h00), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd1), 6'b110001);
    // ports 0,1 blocked: only requester 0 on port 2, ptr -> 1
    add(1'b1, 6'b000111, tg(7'h50,7'h51,7'h52,7'h00,7'h00,7'h00), 3'b011, 6'b000001, 3'b100, pk3(7'h00,7'h00,7'h50), sl(2'd2,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b100010);
    // all ports blocked: nothing granted, ptr stays 1
    add(1'b1, 6'b000110, tg(7'h00,7'h51,7'h52,7'h00,7'h00,7'h00), 3'b111, 6'b000000, 3'b000, pk3(7'h00,7'h00,7'h00), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b000001);
    // scan resumes at 1, ptr -> 3
    add(1'b1, 6'b000110, tg(7'h00,7'h51,7'h52,7'h00,7'h00,7'h00), 3'b000, 6'b000110, 3'b011, pk3(7'h51,7'h52,7'h00), sl(2'd0,2'd0,2'd1,2'd0,2'd0,2'd0), 6'b000000);
    // requester 5 alone, ptr -> 0
    add(1'b1, 6'b100000, tg(7'h00,7'h00,7'h00,7'h00,7'h00,7'h60), 3'b000, 6'b100000, 3'b001, pk3(7'h60,7'h00,7'h00), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b000110);
    // duplicate tags on requesters 0 and 4, ptr -> 5
`ifdef RF_READ_SHARE_EN
    add(1'b1, 6'b010011, tg(7'h11,7'h22,7'h00,7'h00,7'h11,7'h00), 3'b000, 6'b010011, 3'b011, pk3(7'h11,7'h22,7'h00), sl(2'd0,2'd1,2'd0,2'd0,2'd0,2'd0), 6'b100000);
`else
    add(1'b1, 6'b010011, tg(7'h11,7'h22,7'h00,7'h00,7'h11,7'h00), 3'b000, 6'b010011, 3'b111, pk3(7'h11,7'h22,7'h11), sl(2'd0,2'd1,2'd0,2'd0,2'd2,2'd0), 6'b100000);
`endif
    // scan 5,0,1,2 grants requester 2 on port 0
    add(1'b1, 6'b000100, tg(7'h00,7'h00,7'h70,7'h00,7'h00,7'h00), 3'b000, 6'b000100, 3'b001, pk3(7'h70,7'h00,7'h00), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b010011);
    // reset held with a pending request: no grant, previous response still visible
    add(1'b0, 6'b000100, tg(7'h00,7'h00,7'h70,7'h00,7'h00,7'h00), 3'b000, 6'b000000, 3'b000, pk3(7'h00,7'h00,7'h00), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b000100);
    // after reset: no response; ptr back at 0 so 2 beats 5 for the single free port
    add(1'b1, 6'b100100, tg(7'h00,7'h00,7'h70,7'h00,7'h00,7'h75), 3'b110, 6'b000100, 3'b001, pk3(7'h70,7'h00,7'h00), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b000000);
    add(1'b1, 6'b000000, tg(7'h00,7'h00,7'h00,7'h00,7'h00,7'h00), 3'b000, 6'b000000, 3'b000, pk3(7'h00,7'h00,7'h00), sl(2'd0,2'd0,2'd0,2'd0,2'd0,2'd0), 6'b000100);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      drive(i, vq[i].rst, vq[i].valid, vq[i].tags, vq[i].blk);
      @(negedge clk);
      chk($sformatf("v%0d ready", i), 64'(OUT_reqReady), 64'(vq[i].rdy));
      chk($sformatf("v%0d enable", i), 64'(OUT_readEnable), 64'(vq[i].en));
      chk($sformatf("v%0d address", i), 64'(OUT_readAddress), 64'(vq[i].addr));
      chk($sformatf("v%0d rspValid", i), 64'(OUT_rspValid), 64'(vq[i].rspv));
      for (int r = 0; r < 6; r++) begin
        if (vq[i].rspv[r]) begin
          exp_d = rd(i, int'(prev_sel[r*2 +: 2]));
          chk($sformatf("v%0d rspData[%0d]", i, r), 64'(OUT_rspData[r*32 +: 32]), 64'(exp_d));
        end
      end
`ifdef RF_READ_SHARE_EN
      if (vq[i].rspv == 6'b010011)
        chk("shared rspData4 vs rspData0", 64'(OUT_rspData[4*32 +: 32]), 64'(OUT_rspData[0 +: 32]));
`endif
      prev_sel = vq[i].sel;
    end

    // Stall-hold: one free port, requesters 2 and 3 pending from ptr 0
    @(posedge clk); #1;
    drive(100, 1'b0, 6'b0, 42'b0, 3'b000);
    @(posedge clk); #1;
    chk_en = 1'b1;
    drive(101, 1'b1, 6'b001100, tg(7'h00,7'h00,7'h2A,7'h3B,7'h00,7'h00), 3'b110);
    @(negedge clk);
    chk("stall c1 ready", 64'(OUT_reqReady), 64'(6'b000100));
    chk("stall c1 address", 64'(OUT_readAddress), 64'(pk3(7'h2A,7'h00,7'h00)));
    chk("stall c1 rspValid", 64'(OUT_rspValid), 64'(6'b000000));
    @(posedge clk); #1;
    drive(102, 1'b1, 6'b001000, tg(7'h00,7'h00,7'h00,7'h3B,7'h00,7'h00), 3'b110);
    @(negedge clk);
    chk("stall c2 ready", 64'(OUT_reqReady), 64'(6'b001000));
    chk("stall c2 address", 64'(OUT_readAddress), 64'(pk3(7'h3B,7'h00,7'h00)));
    chk("stall c2 rspValid", 64'(OUT_rspValid), 64'(6'b000100));
    chk("stall c2 rspData[2]", 64'(OUT_rspData[2*32 +: 32]), 64'(rd(102, 0)));
    @(posedge clk); #1;
    drive(103, 1'b1, 6'b000000, 42'b0, 3'b110);
    @(negedge clk);
    chk("stall c3 ready", 64'(OUT_reqReady), 64'(6'b000000));
    chk("stall c3 rspValid", 64'(OUT_rspValid), 64'(6'b001000));
    chk("stall c3 rspData[3]", 64'(OUT_rspData[3*32 +: 32]), 64'(rd(103, 0)));
    @(posedge clk); #1;
    chk_en = 1'b0;
    drive(104, 1'b1, 6'b000000, 42'b0, 3'b000);
    @(negedge clk);
    chk("stall c4 rspValid", 64'(OUT_rspValid), 64'(6'b000000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
